// File: rtl/irq_pkg.sv
// Shared sizing and FSM state encoding for the interrupt pending controller.
package irq_pkg;

    localparam int unsigned N     = 8;
    localparam int unsigned IDX_W = 3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ASSERT = 2'd1,
        ST_GAP    = 2'd2
    } state_e;

endpackage

// File: rtl/irq_pending_ctrl_if.sv
// Request/mask/handshake bundle between the interrupt controller and its environment.
interface irq_pending_ctrl_if;

    logic [irq_pkg::N-1:0]     req;
    logic                      mask_we;
    logic [irq_pkg::N-1:0]     mask_wd;
    logic                      ack;
    logic                      irq;
    logic [irq_pkg::IDX_W-1:0] vec;
    logic [irq_pkg::N-1:0]     pending;

    modport master (
        output req, mask_we, mask_wd, ack,
        input  irq, vec, pending
    );

    modport slave (
        input  req, mask_we, mask_wd, ack,
        output irq, vec, pending
    );

endinterface

// File: rtl/irq_pending_ctrl_prio_enc.sv
// 8-to-3 priority encoder, bit 7 highest; output is 0 for an all-zero input.
module PriorityEncoder (
    input  logic [7:0] D,
    output logic [2:0] a
);

    always_comb begin
        a = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (D[i]) begin
                a = 3'(i);
            end
        end
    end

endmodule

// File: rtl/irq_pending_ctrl.sv
// Rising-edge interrupt latch with enable mask, priority select and irq/ack handshake.
// Each accepted ack clears one pending bit; a GAP cycle forces irq low between services.
module irq_pending_ctrl
    import irq_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    irq_pending_ctrl_if.slave  bus
);

    logic [N-1:0]     req_q;
    logic [N-1:0]     pending_q, pending_d;
    logic [N-1:0]     mask_q;
    logic [IDX_W-1:0] vec_q, vec_d;
    logic             irq_q, irq_d;
    state_e           state_q, state_d;

    logic [N-1:0]     rise;
    logic [N-1:0]     act;
    logic [N-1:0]     clr;
    logic [IDX_W-1:0] enc_idx;

    assign rise = bus.req & ~req_q;
    assign act  = pending_q & mask_q;

    PriorityEncoder u_prio_enc (
        .D (act),
        .a (enc_idx)
    );

    // Next-state, vector capture and pending clear; set wins over clear.
    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        clr     = '0;
        case (state_q)
            ST_IDLE: begin
                if (act != '0) begin
                    vec_d   = enc_idx;
                    state_d = ST_ASSERT;
                end
            end
            ST_ASSERT: begin
                if (bus.ack) begin
                    clr[vec_q] = 1'b1;
                    state_d    = ST_GAP;
                end
            end
            ST_GAP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        irq_d     = (state_d == ST_ASSERT);
        pending_d = (pending_q & ~clr) | rise;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            req_q     <= '0;
            pending_q <= '0;
            mask_q    <= '0;
            vec_q     <= '0;
            irq_q     <= 1'b0;
            state_q   <= ST_IDLE;
        end else begin
            req_q     <= bus.req;
            pending_q <= pending_d;
            vec_q     <= vec_d;
            irq_q     <= irq_d;
            state_q   <= state_d;
            if (bus.mask_we) begin
                mask_q <= bus.mask_wd;
            end
        end
    end

    assign bus.irq     = irq_q;
    assign bus.vec     = vec_q;
    assign bus.pending = pending_q;

endmodule

// File: tb/tb_irq_pending_ctrl.sv
// Directed bench for irq_pending_ctrl: edge capture, priority order, masking,
// no preemption, set-over-clear and reset mid-handshake.
module tb_irq_pending_ctrl;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    irq_pending_ctrl_if bus ();

    irq_pending_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge; inputs changed afterwards are sampled at the next edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_mask(input logic [7:0] m);
        bus.mask_we = 1'b1;
        bus.mask_wd = m;
        step();
        bus.mask_we = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    // Ack the current service; irq stays low through GAP and IDLE.
    task automatic ack_service(input string tag, input logic [7:0] exp_pend);
        bus.ack = 1'b1;
        step();
        bus.ack = 1'b0;
        chk({tag, "_irq_after_ack"}, 32'(bus.irq), 32'd0);
        chk({tag, "_pend_after_ack"}, 32'(bus.pending), 32'(exp_pend));
        step();
        chk({tag, "_irq_gap"}, 32'(bus.irq), 32'd0);
    endtask

    initial begin
        logic [2:0] exp_seq [4];
        logic [7:0] pend_seq [4];
        exp_seq  = '{3'd5, 3'd4, 3'd3, 3'd1};
        pend_seq = '{8'h1A, 8'h0A, 8'h02, 8'h00};
        n_checks = 0;
        n_errors = 0;
        rst = 1'b1;
        bus.req = '0;
        bus.mask_we = 1'b0;
        bus.mask_wd = '0;
        bus.ack = 1'b0;

        // Basic single request
        do_reset();
        chk("rst_irq", 32'(bus.irq), 32'd0);
        chk("rst_vec", 32'(bus.vec), 32'd0);
        chk("rst_pend", 32'(bus.pending), 32'd0);
        write_mask(8'hFF);
        bus.req = 8'h02;
        step();
        bus.req = 8'h00;
        chk("s1_pend", 32'(bus.pending), 32'h02);
        chk("s1_irq_early", 32'(bus.irq), 32'd0);
        step();
        chk("s1_irq", 32'(bus.irq), 32'd1);
        chk("s1_vec", 32'(bus.vec), 32'd1);
        ack_service("s1", 8'h00);
        step();
        chk("s1_idle", 32'(bus.irq), 32'd0);

        // Four simultaneous events served highest first
        bus.req = 8'b0011_1010;
        step();
        bus.req = 8'h00;
        chk("s2_pend", 32'(bus.pending), 32'h3A);
        step();
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("s2_irq%0d", i), 32'(bus.irq), 32'd1);
            chk($sformatf("s2_vec%0d", i), 32'(bus.vec), 32'(exp_seq[i]));
            ack_service($sformatf("s2_%0d", i), pend_seq[i]);
            step();
        end
        chk("s2_done_irq", 32'(bus.irq), 32'd0);

        // Masked bit waits; mask change does not preempt
        do_reset();
        write_mask(8'h0F);
        bus.req = 8'h84;
        step();
        bus.req = 8'h00;
        step();
        chk("s3_vec2", 32'(bus.vec), 32'd2);
        chk("s3_irq2", 32'(bus.irq), 32'd1);
        write_mask(8'hFF);
        chk("s3_hold_vec", 32'(bus.vec), 32'd2);
        chk("s3_hold_irq", 32'(bus.irq), 32'd1);
        ack_service("s3a", 8'h80);
        step();
        chk("s3_irq7", 32'(bus.irq), 32'd1);
        chk("s3_vec7", 32'(bus.vec), 32'd7);
        ack_service("s3b", 8'h00);
        step();

        // Higher request during ASSERT does not preempt
        bus.req = 8'h08;
        step();
        bus.req = 8'h00;
        step();
        chk("s4_vec3", 32'(bus.vec), 32'd3);
        bus.req = 8'h40;
        step();
        bus.req = 8'h00;
        chk("s4_hold_vec", 32'(bus.vec), 32'd3);
        chk("s4_pend", 32'(bus.pending), 32'h48);
        ack_service("s4a", 8'h40);
        step();
        chk("s4_vec6", 32'(bus.vec), 32'd6);
        ack_service("s4b", 8'h00);
        step();

        // New rise on the acked bit keeps it pending
        bus.req = 8'h10;
        step();
        bus.req = 8'h00;
        step();
        chk("s5_vec4", 32'(bus.vec), 32'd4);
        bus.req = 8'h10;
        ack_service("s5a", 8'h10);
        bus.req = 8'h00;
        step();
        chk("s5_reserve_irq", 32'(bus.irq), 32'd1);
        chk("s5_reserve_vec", 32'(bus.vec), 32'd4);
        ack_service("s5b", 8'h00);
        step();

        // Reset mid-handshake with held-high requests
        bus.req = 8'h90;
        step();
        chk("s6_pend", 32'(bus.pending), 32'h90);
        step();
        chk("s6_irq", 32'(bus.irq), 32'd1);
        chk("s6_vec", 32'(bus.vec), 32'd7);
        rst = 1'b1;
        step();
        chk("s6_rst_irq", 32'(bus.irq), 32'd0);
        chk("s6_rst_pend", 32'(bus.pending), 32'h00);
        chk("s6_rst_vec", 32'(bus.vec), 32'd0);
        rst = 1'b0;
        step();
        chk("s6_rereg_pend", 32'(bus.pending), 32'h90);
        bus.ack = 1'b1;
        step();
        bus.ack = 1'b0;
        chk("s6_mask0_irq", 32'(bus.irq), 32'd0);
        chk("s6_idle_ack_pend", 32'(bus.pending), 32'h90);
        write_mask(8'hFF);
        chk("s6_mask_lat_irq", 32'(bus.irq), 32'd0);
        step();
        chk("s6_unmask_irq", 32'(bus.irq), 32'd1);
        chk("s6_unmask_vec", 32'(bus.vec), 32'd7);
        bus.req = 8'h00;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
